seq_div_32: RTL

SEQ_DIV_32 -- requirements
Module: seq_div_32

---
 rtl/seq_div_32_if.sv | 14 +
 rtl/seq_div_32.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_div_32_if.sv
// Request/response bundle for the 32-bit sequential divider.
// The master side drives the operation request; the slave side returns status and result.
interface seq_div_32_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, op, dividend, divisor, input busy, done, result);
  modport slave  (input start, op, dividend, divisor, output busy, done, result);
endinterface

// File: rtl/seq_div_32.sv
// 32-bit restoring divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Divide-by-zero and signed overflow skip the iteration and complete one cycle after accept.
module seq_div_32 (
  input  logic         clk,
  input  logic         rst,
  seq_div_32_if.slave  bus
);
  // state | meaning
  // IDLE  | waiting for start
  // CALC  | 32 shift-subtract steps
  // FIN   | result valid, done pulse
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        is_signed, neg_a, neg_b;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, trial;
  logic [31:0] q_step, r_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    is_signed = ~bus.op[0];
    neg_a     = is_signed & bus.dividend[31];
    neg_b     = is_signed & bus.divisor[31];
    a_abs     = neg_a ? -bus.dividend : bus.dividend;
    b_abs     = neg_b ? -bus.divisor : bus.divisor;

    // Remainder never exceeds the divisor, so a 33-bit trial is enough to see the sign.
    rem_sh    = {rem_q, quo_q[31]};
    trial     = rem_sh - {1'b0, dvsr_q};
    q_step    = {quo_q[30:0], ~trial[32]};
    r_step    = trial[32] ? rem_sh[31:0] : trial[31:0];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          busy_d = 1'b1;
          if (bus.divisor == 32'd0) begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = bus.op[1] ? bus.dividend : 32'hFFFF_FFFF;
          end else if (is_signed && bus.dividend == 32'h8000_0000 &&
                       bus.divisor == 32'hFFFF_FFFF) begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = bus.op[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d   = CALC;
            cnt_d     = 6'd32;
            rem_d     = 32'd0;
            quo_d     = a_abs;
            dvsr_d    = b_abs;
            neg_quo_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
          end
        end
      end
      CALC: begin
        quo_d = q_step;
        rem_d = r_step;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = FIN;
          done_d  = 1'b1;
          if (op_q[1])
            result_d = neg_rem_q ? -r_step : r_step;
          else
            result_d = neg_quo_q ? -q_step : q_step;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 2'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
